vga_timing_gen: RTL

Pixel-timing generator for the VGA display path. It produces horizontal and vertical sync, blanking, and the current pixel coordinates (x, y) consumed by the pixel/sprite stage. It also produces one-cycle line, frame and update strobes, so downstream motion logic no longer needs its own VSync edge detector. It runs on the synthesized pixel clock from `clocksyn` and replaces ad-hoc sync counters in the top level.

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: position counters, sync/blank decode and
// line/frame/update strobes, all registered and aligned to the same pixel.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  output logic        HS,
  output logic        VS,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        blank,
  output logic        LINE,
  output logic        FRAME,
  output logic        UPD
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048) begin : g_h_too_big
      $error("vga_timing_gen: H_TOTAL %0d exceeds the 11-bit x counter", H_TOTAL);
    end
    if (V_TOTAL > 1024) begin : g_v_too_big
      $error("vga_timing_gen: V_TOTAL %0d exceeds the 10-bit y counter", V_TOTAL);
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds carry one spare bit so an edge equal to the full total
  // (e.g. zero back porch at 2048) cannot wrap to zero.
  localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEGIN  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_nxt;
  logic [9:0]  y_nxt;
  logic        hs_nxt, vs_nxt, blank_nxt;
  logic        line_nxt, frame_nxt, upd_nxt;

  // Everything is decoded from the next position so the registered outputs
  // describe the same pixel as the registered x/y.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    x_nxt = x + 11'd1;
    y_nxt = y;
    if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
    end

    hs_nxt    = (({1'b0, x_nxt} >= HS_BEGIN) && ({1'b0, x_nxt} < HS_END)) ? HS_POL : ~HS_POL;
    vs_nxt    = (({1'b0, y_nxt} >= VS_BEGIN) && ({1'b0, y_nxt} < VS_END)) ? VS_POL : ~VS_POL;
    blank_nxt = ({1'b0, x_nxt} >= H_ACT_END) || ({1'b0, y_nxt} >= V_ACT_END);

    line_nxt  = (x_nxt == '0);
    frame_nxt = line_nxt && (y_nxt == '0);
    upd_nxt   = line_nxt && ({1'b0, y_nxt} == V_ACT_END);
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      x     <= '0;
      y     <= '0;
      HS    <= ~HS_POL;
      VS    <= ~VS_POL;
      blank <= 1'b0;
      LINE  <= 1'b0;
      FRAME <= 1'b0;
      UPD   <= 1'b0;
    end else if (CE) begin
      x     <= x_nxt;
      y     <= y_nxt;
      HS    <= hs_nxt;
      VS    <= vs_nxt;
      blank <= blank_nxt;
      LINE  <= line_nxt;
      FRAME <= frame_nxt;
      UPD   <= upd_nxt;
    end else begin
      // Position and decode hold; strobes only mark a freshly entered pixel.
      LINE  <= 1'b0;
      FRAME <= 1'b0;
      UPD   <= 1'b0;
    end
  end

endmodule
